// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: sizes, RV32I opcode/funct3 codes and the entry record
package reservation_station_pkg;
    localparam int RS_BITS = 4;
    localparam int RS_SIZE = 2 ** RS_BITS;
    localparam int ROB_BITS = 4;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SLT = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_SR = 3'd5;
    localparam logic [2:0] F3_OR = 3'd6;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;
    localparam logic [2:0] F3_BLT = 3'd4;
    localparam logic [2:0] F3_BGE = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    typedef struct packed {
        logic                busy;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7_5;
        logic [31:0]         pc;
        logic [31:0]         imm;
        logic [ROB_BITS-1:0] rob_id;
        logic [31:0]         vj;
        logic [31:0]         vk;
        logic                qj_busy;
        logic                qk_busy;
        logic [ROB_BITS-1:0] qj;
        logic [ROB_BITS-1:0] qk;
    } rs_entry_t;
endpackage

// File: rtl/reservation_station_if.sv
// reservation_station_if: issue, RoB broadcast/clear and RS-finish signals
interface reservation_station_if;
    import reservation_station_pkg::*;
    logic                issue_ready;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic [31:0]         pc;
    logic [31:0]         imm;
    logic [ROB_BITS-1:0] rob_id;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic                qj_busy;
    logic                qk_busy;
    logic [ROB_BITS-1:0] qj;
    logic [ROB_BITS-1:0] qk;
    logic                RoB_rdy_1;
    logic [ROB_BITS-1:0] RoB_id_1;
    logic [31:0]         RoB_value_1;
    logic                RoB_rdy_2;
    logic [ROB_BITS-1:0] RoB_id_2;
    logic [31:0]         RoB_value_2;
    logic                RoB_clear;
    logic                full;
    logic                RS_finish_rdy;
    logic [ROB_BITS-1:0] RS_finish_id;
    logic [31:0]         RS_finish_value;
    modport master (
        output issue_ready, opcode, funct3, funct7_5, pc, imm, rob_id, vj, vk, qj_busy, qk_busy, qj, qk,
        output RoB_rdy_1, RoB_id_1, RoB_value_1, RoB_rdy_2, RoB_id_2, RoB_value_2, RoB_clear,
        input full, RS_finish_rdy, RS_finish_id, RS_finish_value
    );
    modport slave (
        input issue_ready, opcode, funct3, funct7_5, pc, imm, rob_id, vj, vk, qj_busy, qk_busy, qj, qk,
        input RoB_rdy_1, RoB_id_1, RoB_value_1, RoB_rdy_2, RoB_id_2, RoB_value_2, RoB_clear,
        output full, RS_finish_rdy, RS_finish_id, RS_finish_value
    );
endinterface

// File: rtl/reservation_station_alu.sv
// reservation_station_alu: combinational execute for ALU, upper-immediate, jump and branch ops
module reservation_station_alu
    import reservation_station_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] vj,
    input  logic [31:0] vk,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] result
);
    logic [31:0] b;
    logic [31:0] sra;
    logic [31:0] alu;
    logic        taken;
    always_comb begin
        b = (opcode == OP_R) ? vk : imm;
        sra = $signed(vj) >>> b[4:0];
        case (funct3)
            F3_ADD:  alu = (opcode == OP_R && funct7_5) ? vj - b : vj + b;
            F3_SLL:  alu = vj << b[4:0];
            F3_SLT:  alu = {31'd0, $signed(vj) < $signed(b)};
            F3_SLTU: alu = {31'd0, vj < b};
            F3_XOR:  alu = vj ^ b;
            F3_SR:   alu = funct7_5 ? sra : vj >> b[4:0];
            F3_OR:   alu = vj | b;
            default: alu = vj & b;
        endcase
        case (funct3)
            F3_BEQ:  taken = vj == vk;
            F3_BNE:  taken = vj != vk;
            F3_BLT:  taken = $signed(vj) < $signed(vk);
            F3_BGE:  taken = $signed(vj) >= $signed(vk);
            F3_BLTU: taken = vj < vk;
            default: taken = vj >= vk;
        endcase
        result = opcode == OP_LUI   ? imm :
                 opcode == OP_AUIPC ? pc + imm :
                 opcode == OP_JAL   ? pc + 32'd4 :
                 opcode == OP_JALR  ? (vj + imm) & ~32'd1 :
                 opcode == OP_B     ? {31'd0, taken} : alu;
    end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds issued non-memory ops until operands arrive, executes one per cycle
module reservation_station
    import reservation_station_pkg::*;
(
    input logic                  clk_in,
    input logic                  rst_in,
    input logic                  rdy_in,
    reservation_station_if.slave rs
);
    rs_entry_t           entry_q [RS_SIZE];
    rs_entry_t           entry_d [RS_SIZE];
    rs_entry_t           new_e;
    logic [RS_SIZE-1:0]  busy;
    logic [RS_BITS-1:0]  sel;
    logic [RS_BITS-1:0]  slot;
    logic                sel_valid;
    logic                slot_valid;
    logic                no_j;
    logic                no_k;
    logic [31:0]         alu_result;
    logic                finish_rdy_q, finish_rdy_d;
    logic [ROB_BITS-1:0] finish_id_q, finish_id_d;
    logic [31:0]         finish_value_q, finish_value_d;
    logic                r1, r2;
    logic [ROB_BITS-1:0] id1, id2;
    logic [31:0]         v1, v2;
    assign r1 = rs.RoB_rdy_1;
    assign r2 = rs.RoB_rdy_2;
    assign id1 = rs.RoB_id_1;
    assign id2 = rs.RoB_id_2;
    assign v1 = rs.RoB_value_1;
    assign v2 = rs.RoB_value_2;
    function automatic rs_entry_t wake(rs_entry_t e);
        wake = e;
        if (e.qj_busy && r1 && id1 == e.qj) begin
            wake.vj = v1;
            wake.qj_busy = 1'b0;
        end else if (e.qj_busy && r2 && id2 == e.qj) begin
            wake.vj = v2;
            wake.qj_busy = 1'b0;
        end
        if (e.qk_busy && r1 && id1 == e.qk) begin
            wake.vk = v1;
            wake.qk_busy = 1'b0;
        end else if (e.qk_busy && r2 && id2 == e.qk) begin
            wake.vk = v2;
            wake.qk_busy = 1'b0;
        end
    endfunction
    reservation_station_alu u_alu (
        .opcode  (entry_q[sel].opcode),
        .funct3  (entry_q[sel].funct3),
        .funct7_5(entry_q[sel].funct7_5),
        .vj      (entry_q[sel].vj),
        .vk      (entry_q[sel].vk),
        .imm     (entry_q[sel].imm),
        .pc      (entry_q[sel].pc),
        .result  (alu_result)
    );
    always_comb begin
        sel = '0;
        sel_valid = 1'b0;
        slot = '0;
        slot_valid = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            busy[i] = entry_q[i].busy;
            if (entry_q[i].busy && !entry_q[i].qj_busy && !entry_q[i].qk_busy) begin
                sel = RS_BITS'(i);
                sel_valid = 1'b1;
            end
        end
        // the entry leaving this edge counts as free so issue can reuse it at once
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i] || (sel_valid && sel == RS_BITS'(i))) begin
                slot = RS_BITS'(i);
                slot_valid = 1'b1;
            end
        end
        no_j = rs.opcode == OP_LUI || rs.opcode == OP_AUIPC || rs.opcode == OP_JAL;
        no_k = no_j || rs.opcode == OP_JALR;
        new_e = '{busy: 1'b1, opcode: rs.opcode, funct3: rs.funct3, funct7_5: rs.funct7_5,
                  pc: rs.pc, imm: rs.imm, rob_id: rs.rob_id, vj: rs.vj, vk: rs.vk,
                  qj_busy: rs.qj_busy && !no_j, qk_busy: rs.qk_busy && !no_k, qj: rs.qj, qk: rs.qk};
        new_e = wake(new_e);
        for (int i = 0; i < RS_SIZE; i++) entry_d[i] = entry_q[i].busy ? wake(entry_q[i]) : entry_q[i];
        if (sel_valid) entry_d[sel].busy = 1'b0;
        if (rs.issue_ready && slot_valid) entry_d[slot] = new_e;
        if (rs.RoB_clear) for (int i = 0; i < RS_SIZE; i++) entry_d[i].busy = 1'b0;
        finish_rdy_d = sel_valid && !rs.RoB_clear;
        finish_id_d = finish_rdy_d ? entry_q[sel].rob_id : '0;
        finish_value_d = finish_rdy_d ? alu_result : '0;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
            finish_rdy_q <= 1'b0;
            finish_id_q <= '0;
            finish_value_q <= '0;
        end else if (rdy_in) begin
            entry_q <= entry_d;
            finish_rdy_q <= finish_rdy_d;
            finish_id_q <= finish_id_d;
            finish_value_q <= finish_value_d;
        end
    end
    assign rs.full = &busy;
    assign rs.RS_finish_rdy = finish_rdy_q;
    assign rs.RS_finish_id = finish_id_q;
    assign rs.RS_finish_value = finish_value_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed and random checks against a slot-level reference model
module tb_reservation_station;
    import reservation_station_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    reservation_station_if rs_if ();
    reservation_station dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rs(rs_if));
    typedef struct {
        logic        busy;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [31:0] pc, imm, vj, vk;
        logic        jr, kr;
        logic [3:0]  qj, qk, id;
    } slot_t;
    slot_t       m [16];
    logic        e_rdy;
    logic [3:0]  e_id;
    logic [31:0] e_val;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] expect_result(slot_t s);
        logic [31:0] b, sra;
        b = (s.op == OP_R) ? s.vk : s.imm;
        sra = $signed(s.vj) >>> b[4:0];
        if (s.op == OP_LUI) return s.imm;
        if (s.op == OP_AUIPC) return s.pc + s.imm;
        if (s.op == OP_JAL) return s.pc + 32'd4;
        if (s.op == OP_JALR) return (s.vj + s.imm) & 32'hFFFF_FFFE;
        if (s.op == OP_B) begin
            case (s.f3)
                3'd0: return 32'(s.vj == s.vk);
                3'd1: return 32'(s.vj != s.vk);
                3'd4: return 32'($signed(s.vj) < $signed(s.vk));
                3'd5: return 32'($signed(s.vj) >= $signed(s.vk));
                3'd6: return 32'(s.vj < s.vk);
                default: return 32'(s.vj >= s.vk);
            endcase
        end
        case (s.f3)
            3'd0: return (s.op == OP_R && s.f75) ? s.vj - b : s.vj + b;
            3'd1: return s.vj << b[4:0];
            3'd2: return 32'($signed(s.vj) < $signed(b));
            3'd3: return 32'(s.vj < b);
            3'd4: return s.vj ^ b;
            3'd5: return s.f75 ? sra : s.vj >> b[4:0];
            3'd6: return s.vj | b;
            default: return s.vj & b;
        endcase
    endfunction
    function automatic logic [32:0] snoop(logic [3:0] q);
        if (rs_if.RoB_rdy_1 && rs_if.RoB_id_1 == q) return {1'b1, rs_if.RoB_value_1};
        if (rs_if.RoB_rdy_2 && rs_if.RoB_id_2 == q) return {1'b1, rs_if.RoB_value_2};
        return 33'd0;
    endfunction
    function automatic slot_t wake_slot(slot_t s);
        logic [32:0] h;
        if (!s.jr) begin
            h = snoop(s.qj);
            if (h[32]) begin s.jr = 1'b1; s.vj = h[31:0]; end
        end
        if (!s.kr) begin
            h = snoop(s.qk);
            if (h[32]) begin s.kr = 1'b1; s.vk = h[31:0]; end
        end
        return s;
    endfunction
    function automatic logic model_full();
        for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction
    task automatic model_step();
        slot_t n [16];
        slot_t s;
        int sel = -1;
        int slot = -1;
        if (rst) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            e_rdy = 1'b0; e_id = 4'd0; e_val = 32'd0;
            return;
        end
        if (!rdy) return;
        for (int i = 15; i >= 0; i--) if (m[i].busy && m[i].jr && m[i].kr) sel = i;
        n = m;
        for (int i = 0; i < 16; i++) if (n[i].busy) n[i] = wake_slot(n[i]);
        e_rdy = sel >= 0;
        if (sel >= 0) begin
            e_id = m[sel].id;
            e_val = expect_result(m[sel]);
            n[sel].busy = 1'b0;
        end
        if (rs_if.issue_ready) begin
            for (int i = 15; i >= 0; i--) if (!n[i].busy) slot = i;
            s.busy = 1'b1; s.op = rs_if.opcode; s.f3 = rs_if.funct3; s.f75 = rs_if.funct7_5;
            s.pc = rs_if.pc; s.imm = rs_if.imm; s.vj = rs_if.vj; s.vk = rs_if.vk;
            s.qj = rs_if.qj; s.qk = rs_if.qk; s.id = rs_if.rob_id;
            s.jr = !rs_if.qj_busy || s.op inside {OP_LUI, OP_AUIPC, OP_JAL};
            s.kr = !rs_if.qk_busy || s.op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
            if (slot >= 0) n[slot] = wake_slot(s);
        end
        if (rs_if.RoB_clear) begin
            for (int i = 0; i < 16; i++) n[i].busy = 1'b0;
            e_rdy = 1'b0;
        end
        m = n;
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("finish_rdy", 32'(rs_if.RS_finish_rdy), 32'(e_rdy));
        if (e_rdy) begin
            chk("finish_id", 32'(rs_if.RS_finish_id), 32'(e_id));
            chk("finish_value", rs_if.RS_finish_value, e_val);
        end
        chk("full", 32'(rs_if.full), 32'(model_full()));
    endtask
    task automatic idle();
        rs_if.issue_ready = 1'b0;
        rs_if.RoB_rdy_1 = 1'b0;
        rs_if.RoB_rdy_2 = 1'b0;
        rs_if.RoB_clear = 1'b0;
    endtask
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] id,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk);
        rs_if.issue_ready = 1'b1;
        rs_if.opcode = op; rs_if.funct3 = f3; rs_if.funct7_5 = f75;
        rs_if.pc = pc; rs_if.imm = imm; rs_if.rob_id = id;
        rs_if.vj = vj; rs_if.vk = vk;
        rs_if.qj_busy = qjb; rs_if.qj = qj; rs_if.qk_busy = qkb; rs_if.qk = qk;
    endtask
    task automatic bcast1(input logic [3:0] id, input logic [31:0] v);
        rs_if.RoB_rdy_1 = 1'b1; rs_if.RoB_id_1 = id; rs_if.RoB_value_1 = v;
    endtask
    task automatic bcast2(input logic [3:0] id, input logic [31:0] v);
        rs_if.RoB_rdy_2 = 1'b1; rs_if.RoB_id_2 = id; rs_if.RoB_value_2 = v;
    endtask
    initial begin
        logic [6:0]  ops [7];
        logic [2:0]  bf3 [6];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] r;
        ops = '{OP_R, OP_I, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rdy = 1'b1;
        rst = 1'b1;
        idle();
        issue(OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rs_if.issue_ready = 1'b0;
        rs_if.RoB_id_1 = 0; rs_if.RoB_value_1 = 0; rs_if.RoB_id_2 = 0; rs_if.RoB_value_2 = 0;
        tick();
        tick();
        chk("reset_rdy", 32'(rs_if.RS_finish_rdy), 0);
        chk("reset_id", 32'(rs_if.RS_finish_id), 0);
        chk("reset_value", rs_if.RS_finish_value, 0);
        chk("reset_full", 32'(rs_if.full), 0);
        rst = 1'b0;
        issue(OP_R, 0, 0, 0, 0, 3, 5, 7, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        chk("add_rdy", 32'(rs_if.RS_finish_rdy), 1);
        chk("add_id", 32'(rs_if.RS_finish_id), 3);
        chk("add_value", rs_if.RS_finish_value, 12);
        issue(OP_I, 0, 0, 0, 32'hFFFF_FFFF, 4, 0, 0, 1, 2, 0, 0);
        tick();
        idle();
        bcast2(2, 32'h10);
        tick();
        idle();
        tick();
        chk("addi_rdy", 32'(rs_if.RS_finish_rdy), 1);
        chk("addi_value", rs_if.RS_finish_value, 32'hF);
        issue(OP_B, 3'd0, 0, 0, 0, 5, 9, 9, 0, 0, 0, 0);
        tick();
        issue(OP_B, 3'd1, 0, 0, 0, 6, 9, 9, 0, 0, 0, 0);
        tick();
        chk("beq_value", rs_if.RS_finish_value, 1);
        idle();
        tick();
        chk("bne_id", 32'(rs_if.RS_finish_id), 6);
        chk("bne_value", rs_if.RS_finish_value, 0);
        issue(OP_JALR, 0, 0, 32'h100, 4, 7, 32'h1001, 0, 0, 0, 1, 3);
        tick();
        idle();
        tick();
        chk("jalr_value", rs_if.RS_finish_value, 32'h1004);
        for (int k = 0; k < 16; k++) begin
            issue(OP_R, 0, 0, 0, 0, 4'(k), 0, k, 1, 7, 0, 0);
            tick();
        end
        idle();
        chk("full16", 32'(rs_if.full), 1);
        bcast1(7, 100);
        tick();
        chk("full_wake", 32'(rs_if.full), 1);
        idle();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("drain_id", 32'(rs_if.RS_finish_id), k);
            chk("drain_value", rs_if.RS_finish_value, 100 + k);
            if (k == 0) chk("full_drop", 32'(rs_if.full), 0);
        end
        tick();
        issue(OP_R, 0, 0, 0, 0, 9, 0, 1, 1, 5, 0, 0);
        bcast1(5, -3);
        tick();
        idle();
        tick();
        chk("issue_wake_id", 32'(rs_if.RS_finish_id), 9);
        chk("issue_wake_value", rs_if.RS_finish_value, 32'hFFFF_FFFE);
        for (int k = 0; k < 4; k++) begin
            issue(OP_R, 0, 0, 0, 0, 4'(k), 0, 0, 1, 6, 0, 0);
            tick();
        end
        issue(OP_R, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        chk("pre_clear_rdy", 32'(rs_if.RS_finish_rdy), 1);
        rs_if.RoB_clear = 1'b1;
        bcast1(6, 0);
        issue(OP_R, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0);
        tick();
        chk("clear_rdy", 32'(rs_if.RS_finish_rdy), 0);
        chk("clear_full", 32'(rs_if.full), 0);
        idle();
        bcast1(6, 5);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("clear_quiet", 32'(rs_if.RS_finish_rdy), 0);
        end
        idle();
        issue(OP_R, 0, 0, 0, 0, 12, 1, 2, 0, 0, 0, 0);
        tick();
        issue(OP_R, 0, 0, 0, 0, 13, 3, 4, 0, 0, 0, 0);
        tick();
        idle();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_id", 32'(rs_if.RS_finish_id), 12);
            chk("hold_value", rs_if.RS_finish_value, 3);
        end
        rdy = 1'b1;
        tick();
        chk("resume_id", 32'(rs_if.RS_finish_id), 13);
        chk("resume_value", rs_if.RS_finish_value, 7);
        tick();
        chk("resume_done", 32'(rs_if.RS_finish_rdy), 0);
        issue(OP_R, 0, 0, 0, 0, 14, 0, 0, 1, 8, 0, 0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("midrst_full", 32'(rs_if.full), 0);
        chk("midrst_value", rs_if.RS_finish_value, 0);
        rst = 1'b0;
        bcast1(8, 1);
        tick();
        idle();
        tick();
        chk("midrst_gone", 32'(rs_if.RS_finish_rdy), 0);
        issue(OP_R, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
        tick();
        issue(OP_R, 0, 0, 0, 0, 2, 0, 10, 1, 1, 0, 0);
        tick();
        idle();
        bcast1(1, 5);
        tick();
        idle();
        tick();
        chk("loopback_value", rs_if.RS_finish_value, 15);
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy = $urandom_range(0, 9) != 0;
            rs_if.RoB_clear = $urandom_range(0, 59) == 0;
            if (!model_full() && $urandom_range(0, 2) != 0) begin
                op = ops[$urandom_range(0, 6)];
                f3 = (op == OP_B) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
                r = $urandom;
                issue(op, f3, 1'b0, $urandom, (op == OP_I) ? {{20{r[11]}}, r[11:0]} : r,
                      4'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom,
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom,
                      1'($urandom), 4'($urandom), (op == OP_I) ? 1'b0 : 1'($urandom), 4'($urandom));
                if ((op == OP_R || op == OP_I) && (f3 == 3'd0 || f3 == 3'd5)) rs_if.funct7_5 = 1'($urandom);
                if (op == OP_I && f3 == 3'd1) rs_if.imm[10] = 1'b0;
            end
            if (e_rdy && $urandom_range(0, 3) != 0) bcast1(e_id, e_val);
            else if ($urandom_range(0, 3) == 0) bcast1(4'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) bcast2(4'($urandom), $urandom);
            tick();
        end
        idle();
        rdy = 1'b1;
        for (int k = 0; k < 8; k++) bcast2(4'(k), k);
        repeat (20) begin
            bcast1(4'($urandom), $urandom);
            bcast2(4'($urandom), $urandom);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
